// File: rtl/uart_bus_master.sv
// Bus initiator for the uart register port: turns TX/RX byte streams and divisor
// updates into single-beat bus cycles, with periodic or interrupt-driven RX polling.
module uart_bus_master #(
  parameter int unsigned POLL_INTERVAL = 256,
  parameter logic [31:0] ADDR_BASE     = 32'h0000_0000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [7:0]  tx_byte,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  rx_byte,
  output logic        rx_valid,
  input  logic        rx_ready,
  input  logic [15:0] cfg_div,
  input  logic        cfg_wr,
  output logic        busy,
  output logic [31:0] m_dat_o,
  output logic [31:0] m_adr_o,
  output logic        m_we_o,
  output logic        m_stb_o,
  input  logic [31:0] m_dat_i,
  input  logic        m_ack_i,
  input  logic        rx_irq_i,
  output logic        rx_iack_o
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR_TX   = 3'd1;
  localparam logic [2:0] WR_CFG  = 3'd2;
  localparam logic [2:0] RD_REQ  = 3'd3;
  localparam logic [2:0] RD_WAIT = 3'd4;
  localparam logic [2:0] GAP     = 3'd5;

  localparam int CW = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
  localparam logic [CW-1:0] POLL_RELOAD = CW'(POLL_INTERVAL - 1);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] poll_cnt_q, poll_cnt_d;
  logic          cfg_pend_q, cfg_pend_d;
  logic [15:0]   cfg_val_q, cfg_val_d;
  logic          stb_q, stb_d;
  logic          we_q, we_d;
  logic [1:0]    adr_lo_q, adr_lo_d;
  logic [31:0]   dat_q, dat_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          rx_valid_q, rx_valid_d;
  logic          rx_iack_q, rx_iack_d;
  logic          busy_q, busy_d;
  logic          tx_ready_s;
  logic          cfg_req_s;
  logic [15:0]   cfg_sel_s;
  logic          poll_due_s;
  logic [CW-1:0] poll_dec_s;
  logic          unused_s;

  assign unused_s = ^m_dat_i[31:9];

  // Next-state, bus-output and bookkeeping logic
  always_comb begin
    state_d    = state_q;
    poll_cnt_d = poll_cnt_q;
    cfg_pend_d = cfg_pend_q;
    cfg_val_d  = cfg_val_q;
    stb_d      = stb_q;
    we_d       = we_q;
    adr_lo_d   = adr_lo_q;
    dat_d      = dat_q;
    rx_byte_d  = rx_byte_q;
    rx_valid_d = rx_valid_q;
    rx_iack_d  = rx_iack_q;
    tx_ready_s = 1'b0;

    // A request arriving in IDLE is served at once, so arbitration sees it directly
    cfg_req_s  = cfg_wr | cfg_pend_q;
    cfg_sel_s  = cfg_wr ? cfg_div : cfg_val_q;
    poll_due_s = ((poll_cnt_q == {CW{1'b0}}) | rx_irq_i) & ~rx_valid_q;
    poll_dec_s = (poll_cnt_q != {CW{1'b0}}) ? (poll_cnt_q - CW'(1)) : poll_cnt_q;

    if (cfg_wr) begin
      cfg_pend_d = 1'b1;
      cfg_val_d  = cfg_div;
    end else begin
      cfg_pend_d = cfg_pend_q;
    end

    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end else begin
      rx_valid_d = rx_valid_q;
    end

    case (state_q)
      IDLE: begin
        poll_cnt_d = poll_dec_s;
        if (cfg_req_s) begin
          state_d  = WR_CFG;
          stb_d    = 1'b1;
          we_d     = 1'b1;
          adr_lo_d = 2'd1;
          dat_d    = {16'h0000, cfg_sel_s};
        end else if (poll_due_s) begin
          state_d    = RD_REQ;
          poll_cnt_d = POLL_RELOAD;
          stb_d      = 1'b1;
          we_d       = 1'b0;
          adr_lo_d   = 2'd0;
          dat_d      = 32'h0000_0000;
          rx_iack_d  = 1'b1;
        end else if (tx_valid) begin
          tx_ready_s = 1'b1;
          state_d    = WR_TX;
          stb_d      = 1'b1;
          we_d       = 1'b1;
          adr_lo_d   = 2'd0;
          dat_d      = {24'h00_0000, tx_byte};
        end else begin
          state_d = IDLE;
        end
      end
      WR_TX, WR_CFG: begin
        // Writes stall here for as long as the uart holds ack low
        if (m_ack_i) begin
          state_d  = GAP;
          stb_d    = 1'b0;
          we_d     = 1'b0;
          adr_lo_d = 2'd0;
          dat_d    = 32'h0000_0000;
          if ((state_q == WR_CFG) && !cfg_wr) begin
            cfg_pend_d = 1'b0;
          end else begin
            cfg_pend_d = cfg_pend_d;
          end
        end else begin
          state_d = state_q;
        end
      end
      RD_REQ: begin
        state_d  = RD_WAIT;
        stb_d    = 1'b0;
        we_d     = 1'b0;
        adr_lo_d = 2'd0;
        dat_d    = 32'h0000_0000;
      end
      RD_WAIT: begin
        // Read data is registered in the uart, so it is valid now; bit 8 flags a byte
        state_d   = GAP;
        rx_iack_d = 1'b0;
        if (m_dat_i[8]) begin
          rx_byte_d  = m_dat_i[7:0];
          rx_valid_d = 1'b1;
        end else begin
          rx_byte_d = rx_byte_q;
        end
      end
      GAP: begin
        poll_cnt_d = poll_dec_s;
        state_d    = IDLE;
      end
      default: begin
        state_d   = IDLE;
        stb_d     = 1'b0;
        we_d      = 1'b0;
        adr_lo_d  = 2'd0;
        dat_d     = 32'h0000_0000;
        rx_iack_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= IDLE;
      poll_cnt_q <= POLL_RELOAD;
      cfg_pend_q <= 1'b0;
      cfg_val_q  <= 16'h0000;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      adr_lo_q   <= 2'd0;
      dat_q      <= 32'h0000_0000;
      rx_byte_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      rx_iack_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      poll_cnt_q <= poll_cnt_d;
      cfg_pend_q <= cfg_pend_d;
      cfg_val_q  <= cfg_val_d;
      stb_q      <= stb_d;
      we_q       <= we_d;
      adr_lo_q   <= adr_lo_d;
      dat_q      <= dat_d;
      rx_byte_q  <= rx_byte_d;
      rx_valid_q <= rx_valid_d;
      rx_iack_q  <= rx_iack_d;
      busy_q     <= busy_d;
    end
  end

  assign tx_ready  = tx_ready_s;
  assign rx_byte   = rx_byte_q;
  assign rx_valid  = rx_valid_q;
  assign busy      = busy_q;
  assign m_stb_o   = stb_q;
  assign m_we_o    = we_q;
  assign m_dat_o   = dat_q;
  assign m_adr_o   = {ADDR_BASE[31:2], adr_lo_q};
  assign rx_iack_o = rx_iack_q;

endmodule

// File: tb/tb_uart_bus_master.sv
// Directed bench for uart_bus_master: a tiny uart bus responder plus per-feature tasks.
module tb_uart_bus_master;

  localparam int PI = 256;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        rx_ready;
  logic [15:0] cfg_div;
  logic        cfg_wr;
  logic        busy;
  logic [31:0] m_dat_o;
  logic [31:0] m_adr_o;
  logic        m_we_o;
  logic        m_stb_o;
  logic [31:0] m_dat_i;
  logic        m_ack_i;
  logic        rx_irq_i;
  logic        rx_iack_o;
  logic        wr_ack_en;

  int n_checks = 0;
  int n_fail   = 0;

  uart_bus_master #(.POLL_INTERVAL(PI), .ADDR_BASE(32'h0000_0000)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .cfg_div(cfg_div), .cfg_wr(cfg_wr), .busy(busy),
    .m_dat_o(m_dat_o), .m_adr_o(m_adr_o), .m_we_o(m_we_o), .m_stb_o(m_stb_o),
    .m_dat_i(m_dat_i), .m_ack_i(m_ack_i),
    .rx_irq_i(rx_irq_i), .rx_iack_o(rx_iack_o)
  );

  always #5 sys_clk = ~sys_clk;

  // uart responder: reads always ack, writes ack only when the FIFO has room
  assign m_ack_i = m_stb_o & (m_we_o ? wr_ack_en : 1'b1);

  int          cyc = 0;
  int          stb_cnt = 0;
  int          acc_cnt = 0;
  int          iack_cnt = 0;
  int          inv_err = 0;
  int          ev_n = 0;
  logic        ev_we  [0:63];
  logic [31:0] ev_adr [0:63];
  logic [31:0] ev_dat [0:63];
  int          ev_cyc [0:63];

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Bus monitor: logs every completed cycle and tracks invariants
  always @(negedge sys_clk) begin
    if (m_stb_o) stb_cnt = stb_cnt + 1;
    if (tx_valid && tx_ready) acc_cnt = acc_cnt + 1;
    if (rx_iack_o) iack_cnt = iack_cnt + 1;
    if (!m_stb_o && (m_dat_o != 32'h0 || m_we_o || m_adr_o[1:0] != 2'd0)) inv_err = inv_err + 1;
    if (tx_ready && busy) inv_err = inv_err + 1;
    if (m_stb_o && m_ack_i && ev_n < 64) begin
      ev_we[ev_n]  = m_we_o;
      ev_adr[ev_n] = m_adr_o;
      ev_dat[ev_n] = m_dat_o;
      ev_cyc[ev_n] = cyc;
      ev_n = ev_n + 1;
    end
  end

  task automatic do_reset();
    sys_rst   = 1'b1;
    tx_valid  = 1'b0;
    tx_byte   = 8'h00;
    cfg_wr    = 1'b0;
    cfg_div   = 16'h0000;
    rx_ready  = 1'b0;
    rx_irq_i  = 1'b0;
    m_dat_i   = 32'h0;
    wr_ack_en = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit got = 1'b0;
    tx_byte  = b;
    tx_valid = 1'b1;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge sys_clk);
      if (tx_ready) got = 1'b1;
    end
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL send_byte_timeout: byte %h not accepted within 200 cycles", b);
    end
    @(posedge sys_clk);
    #1 tx_valid = 1'b0;
  endtask

  task automatic test_reset();
    int e0;
    sys_rst = 1'b1; tx_valid = 1'b0; cfg_wr = 1'b0; rx_ready = 1'b0;
    rx_irq_i = 1'b0; m_dat_i = 32'h0; wr_ack_en = 1'b0; tx_byte = 8'h00; cfg_div = 16'h0;
    #1;
    n_checks++;
    if ({m_stb_o, m_we_o, busy, rx_valid, rx_iack_o, tx_ready} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b required 000000",
                         {m_stb_o, m_we_o, busy, rx_valid, rx_iack_o, tx_ready});
    end
    n_checks++;
    if (m_adr_o !== 32'h0 || m_dat_o !== 32'h0) begin
      n_fail++; $display("FAIL reset_bus: adr %h dat %h required 0 0", m_adr_o, m_dat_o);
    end
    repeat (2) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    e0 = ev_n;
    tx_byte = 8'h99; tx_valid = 1'b1;
    @(negedge sys_clk);
    n_checks++;
    if (tx_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_pre_accept: tx_ready %b required 1", tx_ready);
    end
    @(posedge sys_clk);
    #1 tx_valid = 1'b0;
    n_checks++;
    if (m_stb_o !== 1'b1 || m_dat_o !== 32'h99 || busy !== 1'b1) begin
      n_fail++; $display("FAIL reset_wr_tx: stb %b dat %h busy %b required 1 99 1", m_stb_o, m_dat_o, busy);
    end
    #1 sys_rst = 1'b1;
    #1;
    n_checks++;
    if ({m_stb_o, tx_ready, rx_valid, busy, m_we_o} !== 5'b0 || m_adr_o !== 32'h0) begin
      n_fail++; $display("FAIL reset_mid_cycle: stb %b rdy %b vld %b busy %b adr %h required all 0",
                         m_stb_o, tx_ready, rx_valid, busy, m_adr_o);
    end
    repeat (2) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    wr_ack_en = 1'b1;
    repeat (3) @(posedge sys_clk);
    n_checks++;
    if (ev_n !== e0 || m_stb_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_no_cycle: events %0d stb %b required 0 0", ev_n - e0, m_stb_o);
    end
  endtask

  task automatic test_back_to_back();
    int e0, s0, a0;
    do_reset();
    e0 = ev_n; s0 = stb_cnt; a0 = acc_cnt;
    send_byte(8'h41);
    send_byte(8'h42);
    repeat (5) @(posedge sys_clk);
    #1;
    n_checks++;
    if (ev_n - e0 !== 2) begin
      n_fail++; $display("FAIL b2b_count: got %0d writes required 2", ev_n - e0);
    end else begin
      n_checks++;
      if (ev_dat[e0] !== 32'h41 || ev_dat[e0+1] !== 32'h42) begin
        n_fail++; $display("FAIL b2b_data: got %h %h required 41 42", ev_dat[e0], ev_dat[e0+1]);
      end
      n_checks++;
      if (ev_adr[e0] !== 32'h0 || ev_adr[e0+1] !== 32'h0 || ev_we[e0] !== 1'b1 || ev_we[e0+1] !== 1'b1) begin
        n_fail++; $display("FAIL b2b_adr: got %h %h we %b%b required 0 0 11",
                           ev_adr[e0], ev_adr[e0+1], ev_we[e0], ev_we[e0+1]);
      end
      n_checks++;
      if (ev_cyc[e0+1] - ev_cyc[e0] !== 3) begin
        n_fail++; $display("FAIL b2b_spacing: got %0d cycles required 3", ev_cyc[e0+1] - ev_cyc[e0]);
      end
    end
    n_checks++;
    if (stb_cnt - s0 !== 2 || acc_cnt - a0 !== 2) begin
      n_fail++; $display("FAIL b2b_stb: stb cycles %0d accepts %0d required 2 2", stb_cnt - s0, acc_cnt - a0);
    end
  endtask

  task automatic test_tx_stall();
    int e0, s0, a0;
    bit got = 1'b0;
    do_reset();
    wr_ack_en = 1'b0;
    e0 = ev_n; s0 = stb_cnt; a0 = acc_cnt;
    tx_byte = 8'h55; tx_valid = 1'b1;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge sys_clk);
      if (tx_ready) got = 1'b1;
    end
    @(posedge sys_clk);
    #1 tx_valid = 1'b0;
    repeat (20) @(posedge sys_clk);
    #1 wr_ack_en = 1'b1;
    repeat (4) @(posedge sys_clk);
    #1;
    n_checks++;
    if (stb_cnt - s0 !== 21) begin
      n_fail++; $display("FAIL stall_stb_len: got %0d cycles required 21", stb_cnt - s0);
    end
    n_checks++;
    if (ev_n - e0 !== 1 || acc_cnt - a0 !== 1) begin
      n_fail++; $display("FAIL stall_once: writes %0d accepts %0d required 1 1", ev_n - e0, acc_cnt - a0);
    end else begin
      n_checks++;
      if (ev_dat[e0] !== 32'h55 || ev_adr[e0] !== 32'h0) begin
        n_fail++; $display("FAIL stall_data: dat %h adr %h required 55 0", ev_dat[e0], ev_adr[e0]);
      end
    end
  endtask

  task automatic test_rx_irq();
    int e0, i0;
    bit got = 1'b0;
    do_reset();
    e0 = ev_n; i0 = iack_cnt;
    m_dat_i = 32'h0000_01A5;
    rx_irq_i = 1'b1;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge sys_clk);
      if (rx_valid) got = 1'b1;
    end
    n_checks++;
    if (!got || rx_byte !== 8'hA5) begin
      n_fail++; $display("FAIL rx_irq_byte: valid %b byte %h required 1 a5", got, rx_byte);
    end
    repeat (50) @(negedge sys_clk);
    n_checks++;
    if (iack_cnt - i0 !== 2) begin
      n_fail++; $display("FAIL rx_iack_len: got %0d cycles required 2", iack_cnt - i0);
    end
    n_checks++;
    if (ev_n - e0 !== 1 || rx_valid !== 1'b1 || rx_byte !== 8'hA5) begin
      n_fail++; $display("FAIL rx_hold: reads %0d valid %b byte %h required 1 1 a5", ev_n - e0, rx_valid, rx_byte);
    end else begin
      n_checks++;
      if (ev_we[e0] !== 1'b0 || ev_adr[e0] !== 32'h0) begin
        n_fail++; $display("FAIL rx_read_cycle: we %b adr %h required 0 0", ev_we[e0], ev_adr[e0]);
      end
    end
    rx_irq_i = 1'b0;
    m_dat_i = 32'h0;
    rx_ready = 1'b1;
    @(posedge sys_clk);
    #1 rx_ready = 1'b0;
    @(negedge sys_clk);
    n_checks++;
    if (rx_valid !== 1'b0) begin
      n_fail++; $display("FAIL rx_release: valid %b required 0", rx_valid);
    end
  endtask

  task automatic test_poll();
    int e0, c0;
    do_reset();
    c0 = cyc;
    e0 = ev_n;
    for (int k = 0; k < 700 && (ev_n - e0) < 2; k++) @(negedge sys_clk);
    n_checks++;
    if (ev_n - e0 < 2) begin
      n_fail++; $display("FAIL poll_timeout: got %0d reads required 2", ev_n - e0);
    end else begin
      n_checks++;
      if (ev_cyc[e0] - c0 !== PI) begin
        n_fail++; $display("FAIL poll_first: read after %0d cycles required %0d", ev_cyc[e0] - c0, PI);
      end
      n_checks++;
      if (ev_cyc[e0+1] - ev_cyc[e0] !== PI + 2) begin
        n_fail++; $display("FAIL poll_period: got %0d required %0d", ev_cyc[e0+1] - ev_cyc[e0], PI + 2);
      end
      n_checks++;
      if (ev_we[e0] !== 1'b0 || ev_we[e0+1] !== 1'b0 || rx_valid !== 1'b0) begin
        n_fail++; $display("FAIL poll_empty: we %b%b valid %b required 00 0", ev_we[e0], ev_we[e0+1], rx_valid);
      end
    end
  endtask

  task automatic test_cfg_priority();
    int e0, a0;
    bit got = 1'b0;
    do_reset();
    e0 = ev_n; a0 = acc_cnt;
    cfg_div = 16'h0036; cfg_wr = 1'b1;
    tx_byte = 8'h77; tx_valid = 1'b1;
    rx_irq_i = 1'b1;
    @(posedge sys_clk);
    #1 cfg_wr = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge sys_clk);
      if (tx_ready) got = 1'b1;
      if ((ev_n - e0) >= 2) rx_irq_i = 1'b0;
    end
    @(posedge sys_clk);
    #1 tx_valid = 1'b0;
    rx_irq_i = 1'b0;
    repeat (4) @(posedge sys_clk);
    #1;
    n_checks++;
    if (ev_n - e0 !== 3 || acc_cnt - a0 !== 1) begin
      n_fail++; $display("FAIL cfg_count: cycles %0d accepts %0d required 3 1", ev_n - e0, acc_cnt - a0);
    end else begin
      n_checks++;
      if (ev_we[e0] !== 1'b1 || ev_adr[e0] !== 32'h1 || ev_dat[e0] !== 32'h36) begin
        n_fail++; $display("FAIL cfg_first: we %b adr %h dat %h required 1 1 36", ev_we[e0], ev_adr[e0], ev_dat[e0]);
      end
      n_checks++;
      if (ev_we[e0+1] !== 1'b0 || ev_adr[e0+1] !== 32'h0) begin
        n_fail++; $display("FAIL cfg_second_read: we %b adr %h required 0 0", ev_we[e0+1], ev_adr[e0+1]);
      end
      n_checks++;
      if (ev_we[e0+2] !== 1'b1 || ev_adr[e0+2] !== 32'h0 || ev_dat[e0+2] !== 32'h77) begin
        n_fail++; $display("FAIL cfg_third_tx: we %b adr %h dat %h required 1 0 77",
                           ev_we[e0+2], ev_adr[e0+2], ev_dat[e0+2]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_tx_stall();
    test_rx_irq();
    test_poll();
    test_cfg_priority();
    n_checks++;
    if (inv_err !== 0) begin
      n_fail++; $display("FAIL bus_idle_invariant: got %0d violations required 0", inv_err);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
